// File: rtl/dmx_slot_loader_pkg.sv
// Shared constants and state encodings for the DMX slot loader.
package dmx_slot_loader_pkg;

    // Frame header byte that opens every slot-update frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // 12 MHz / 115200 baud.
    localparam int DEF_CLKS_PER_BIT = 104;

    // Idle cycles tolerated between bytes inside a frame (about four byte times).
    localparam int DEF_TIMEOUT_CLKS = 4160;

    // Frame parser states.
    typedef enum logic [2:0] {
        S_CLEAR,
        S_HUNT,
        S_ADDR_HI,
        S_ADDR_LO,
        S_COUNT,
        S_DATA
    } parser_state_t;

    // UART receiver states.
    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

endpackage

// File: rtl/dmx_slot_loader_uart_rx.sv
// 8N1 UART receiver working on an already-synchronised line. A start bit is
// confirmed at its midpoint, data bits are taken LSB-first at bit midpoints,
// and the stop bit decides between a byte_valid pulse and a ferr pulse.
// The received byte is presented on rx_byte ("byte" is a reserved word).
module dmx_slot_loader_uart_rx
    import dmx_slot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       CLK12,
    input  logic       reset,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       ferr
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   r_state;
    uart_state_t   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_rx_prev;
    logic          w_half_done;
    logic          w_full_done;

    assign w_half_done = (r_cnt == HALF_LAST);
    assign w_full_done = (r_cnt == FULL_LAST);
    assign rx_byte     = r_shift;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK12) begin
        if (reset) begin
            r_state <= U_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: edge-triggered start, mid-bit glitch check, 8 data bits, stop bit.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            U_IDLE:  if (r_rx_prev && !rx_sync) w_state_next = U_START;
            U_START: if (w_half_done) w_state_next = rx_sync ? U_IDLE : U_DATA;
            U_DATA:  if (w_full_done && (r_bit_idx == 3'd7)) w_state_next = U_STOP;
            U_STOP:  if (w_full_done) w_state_next = U_IDLE;
            default: w_state_next = U_IDLE;
        endcase
    end

    // Bit-time counter, bit index and LSB-first shift register.
    always_ff @(posedge CLK12) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= rx_sync;
            if ((r_state == U_IDLE) || (r_state != w_state_next) || w_full_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == U_IDLE) begin
                r_bit_idx <= '0;
            end else if ((r_state == U_DATA) && w_full_done) begin
                r_shift   <= {rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    // Outputs: the stop-bit sample produces exactly one of byte_valid or ferr.
    always_comb begin
        byte_valid = 1'b0;
        ferr       = 1'b0;
        if ((r_state == U_STOP) && w_full_done) begin
            byte_valid = rx_sync;
            ferr       = !rx_sync;
        end
    end

endmodule

// File: rtl/dmx_slot_loader.sv
// DMX slot loader: RS232 slot-update frames are parsed into a 512x8 slot
// buffer whose synchronous read port serves the DMX packetizer. After reset
// the whole buffer is swept to zero before frames are accepted.
// Frame: A5, addr_hi (bit 0 only), addr_lo, count (0 = 256), data bytes.
module dmx_slot_loader
    import dmx_slot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic       CLK12,
    input  logic       reset,
    input  logic       rx,
    input  logic [9:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       ready,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          w_byte_valid;
    logic [7:0]    w_rx_byte;
    logic          w_ferr;

    parser_state_t r_state;
    parser_state_t w_state_next;
    logic          w_frame_err;
    logic          w_in_frame;
    logic          w_timeout;

    logic [8:0]    r_clr_addr;
    logic [8:0]    r_addr;
    logic [8:0]    r_remaining;
    logic [TW-1:0] r_tmo;
    logic          r_we;
    logic [8:0]    r_waddr;
    logic [7:0]    r_wdata;
    logic          r_frame_ok;
    logic          r_frame_err;

    logic          w_mem_we;
    logic [8:0]    w_mem_addr;
    logic [7:0]    w_mem_data;
    logic [7:0]    r_mem [0:511];
    logic [7:0]    r_rd_data;

    // Two-flop synchroniser for the asynchronous RS232 line, parked at idle-high.
    always_ff @(posedge CLK12) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    dmx_slot_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .CLK12     (CLK12),
        .reset     (reset),
        .rx_sync   (r_rx_sync),
        .byte_valid(w_byte_valid),
        .rx_byte   (w_rx_byte),
        .ferr      (w_ferr)
    );

    // A frame is open between the sync byte and its last data byte.
    assign w_in_frame = (r_state != S_CLEAR) && (r_state != S_HUNT);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout  = w_in_frame && !w_byte_valid && (r_tmo == TMO_LAST);

    // Parser state register.
    always_ff @(posedge CLK12) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Parser next-state logic, with line errors and timeouts aborting an open frame.
    always_comb begin
        w_state_next = r_state;
        w_frame_err  = 1'b0;
        case (r_state)
            S_CLEAR: if (r_clr_addr == 9'd511) w_state_next = S_HUNT;
            S_HUNT:  if (w_byte_valid && (w_rx_byte == SYNC_BYTE)) w_state_next = S_ADDR_HI;
            S_ADDR_HI: begin
                if (w_byte_valid) begin
                    if (w_rx_byte[7:1] != '0) begin
                        w_state_next = S_HUNT;
                        w_frame_err  = 1'b1;
                    end else begin
                        w_state_next = S_ADDR_LO;
                    end
                end
            end
            S_ADDR_LO: if (w_byte_valid) w_state_next = S_COUNT;
            S_COUNT:   if (w_byte_valid) w_state_next = S_DATA;
            S_DATA:    if (w_byte_valid && (r_remaining == 9'd1)) w_state_next = S_HUNT;
            default:   w_state_next = S_HUNT;
        endcase
        if (w_in_frame && (w_ferr || w_timeout)) begin
            w_state_next = S_HUNT;
            w_frame_err  = 1'b1;
        end
    end

    // Parser datapath: clear pointer, frame address/count, timeout counter, registered write.
    always_ff @(posedge CLK12) begin
        if (reset) begin
            r_clr_addr  <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_tmo       <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= w_frame_err;
            if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            if (!w_in_frame || w_byte_valid) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_byte_valid) begin
                case (r_state)
                    S_ADDR_HI: r_addr[8]   <= w_rx_byte[0];
                    S_ADDR_LO: r_addr[7:0] <= w_rx_byte;
                    S_COUNT:   r_remaining <= (w_rx_byte == 8'h00) ? 9'd256 : {1'b0, w_rx_byte};
                    S_DATA: begin
                        r_we        <= 1'b1;
                        r_waddr     <= r_addr;
                        r_wdata     <= w_rx_byte;
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        r_frame_ok  <= (r_remaining == 9'd1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Single write port: the clear sweep owns it while clearing, frame data otherwise.
    assign w_mem_we   = (r_state == S_CLEAR) || r_we;
    assign w_mem_addr = (r_state == S_CLEAR) ? r_clr_addr : r_waddr;
    assign w_mem_data = (r_state == S_CLEAR) ? 8'h00 : r_wdata;

    // Slot RAM write port.
    // NOTE: the array has no reset so it maps to block RAM; the clear sweep zeroes it instead.
    always_ff @(posedge CLK12) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Registered read port; returns the pre-write value on a same-address collision.
    always_ff @(posedge CLK12) begin
        if (reset) begin
            r_rd_data <= 8'h00;
        end else if (rd_addr[9]) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_mem[rd_addr[8:0]];
        end
    end

    // Outputs.
    always_comb begin
        ready     = (r_state != S_CLEAR);
        frame_ok  = r_frame_ok;
        frame_err = r_frame_err;
        rd_data   = r_rd_data;
    end

endmodule

// File: tb/tb_dmx_slot_loader.sv
// Self-checking bench for dmx_slot_loader. A slot-buffer model is updated
// from whole frames; a compare process checks ready and rd_data against it
// every cycle, and frame pulses are counted against per-test expectations.
module tb_dmx_slot_loader;

    localparam int CPB      = 16;
    localparam int TMO      = 400;
    localparam int BYTE_CYC = 10 * CPB + 4;

    logic       CLK12   = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       ready;
    logic       frame_ok;
    logic       frame_err;

    dmx_slot_loader #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .CLK12    (CLK12),
        .reset    (reset),
        .rx       (rx),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .ready    (ready),
        .frame_ok (frame_ok),
        .frame_err(frame_err)
    );

    always #5 CLK12 = ~CLK12;

    logic [7:0] model_mem [512];
    logic [7:0] seq [$];
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         ok_seen    = 0;
    int         err_seen   = 0;
    int         ok_mark    = 0;
    int         err_mark   = 0;
    int         clr_cycles = 0;
    logic       rd_chk_en  = 1'b0;
    logic       cap_en     = 1'b0;
    logic [9:0] cap_addr   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Capture what the DUT sampled at this edge; count cycles since reset released.
    always @(posedge CLK12) begin
        cap_en   <= rd_chk_en;
        cap_addr <= rd_addr;
        if (reset) clr_cycles <= 0;
        else if (clr_cycles < 512) clr_cycles <= clr_cycles + 1;
    end

    // Compare process: ready every cycle, rd_data whenever the buffer is quiescent.
    always @(negedge CLK12) begin
        check("ready", 32'(ready), (clr_cycles >= 512) ? 32'd1 : 32'd0);
        if (cap_en)
            check("rd_data", 32'(rd_data),
                  (cap_addr >= 10'd512) ? 32'd0 : 32'(model_mem[cap_addr[8:0]]));
        if (frame_ok)  ok_seen  <= ok_seen + 1;
        if (frame_err) err_seen <= err_seen + 1;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge CLK12);
        end
        rx = 1'b1;
        repeat (4) @(negedge CLK12);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i], 1'b1);
    endtask

    // Model: every data byte of seq (a frame header plus data) lands at addr+i mod 512.
    task automatic apply_frame();
        int base;
        base = int'(seq[1][0]) * 256 + int'(seq[2]);
        for (int i = 0; i < seq.size() - 4; i++) model_mem[(base + i) % 512] = seq[4 + i];
    endtask

    task automatic mark();
        ok_mark  = ok_seen;
        err_mark = err_seen;
    endtask

    task automatic expect_pulses(input int exp_ok, input int exp_err, input string name);
        repeat (4) @(negedge CLK12);
        #1;
        check({name, "_frame_ok"}, ok_seen - ok_mark, exp_ok);
        check({name, "_frame_err"}, err_seen - err_mark, exp_err);
    endtask

    task automatic read_check(input logic [9:0] a, input logic [7:0] exp, input string name);
        @(negedge CLK12);
        rd_addr = a;
        @(negedge CLK12);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic sweep();
        @(negedge CLK12);
        rd_chk_en = 1'b1;
        for (int a = 0; a < 512; a++) begin
            rd_addr = 10'(a);
            @(negedge CLK12);
        end
        rd_addr = 10'd700;
        @(negedge CLK12);
        rd_chk_en = 1'b0;
    endtask

    task automatic wait_ready(input int exp_cycles, input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK12);
            n++;
        end while (!ready && n < 600);
        check(name, n, exp_cycles);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model_mem[i] = 8'h00;

        // Reset state, clear sweep length, empty buffer.
        repeat (4) @(negedge CLK12);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_ready(512, "ready_latency");
        sweep();

        // Basic frame at slot 1.
        mark();
        seq = '{8'hA5, 8'h00, 8'h01, 8'h03, 8'hFF, 8'h05, 8'h80};
        send_seq();
        apply_frame();
        expect_pulses(1, 0, "f1");
        read_check(10'd2, 8'h05, "f1_slot2");
        read_check(10'd3, 8'h80, "f1_slot3");

        // Address wrap 511 -> 0, and out-of-range reads.
        mark();
        seq = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22};
        send_seq();
        apply_frame();
        expect_pulses(1, 0, "wrap");
        read_check(10'd511, 8'h11, "wrap_slot511");
        read_check(10'd0, 8'h22, "wrap_slot0");
        read_check(10'd512, 8'h00, "rd_512");
        read_check(10'd1023, 8'h00, "rd_1023");
        sweep();

        // Timeout mid-frame keeps the written byte.
        mark();
        seq = '{8'hA5, 8'h00, 8'h10, 8'h04, 8'hAA};
        send_seq();
        apply_frame();
        repeat (TMO + 50) @(negedge CLK12);
        expect_pulses(0, 1, "timeout");
        read_check(10'd16, 8'hAA, "timeout_slot16");

        // Next frame accepted; long but sub-timeout gaps between bytes.
        mark();
        seq = '{8'hA5, 8'h00, 8'h20, 8'h02};
        send_seq();
        repeat (150) @(negedge CLK12);
        send_byte(8'h5C, 1'b1);
        repeat (150) @(negedge CLK12);
        send_byte(8'hC3, 1'b1);
        model_mem[32] = 8'h5C;
        model_mem[33] = 8'hC3;
        expect_pulses(1, 0, "slow");
        read_check(10'd33, 8'hC3, "slow_slot33");

        // Bad ADDR_HI, then trailing bytes ignored in HUNT.
        mark();
        seq = '{8'hA5, 8'h02, 8'h03, 8'h04};
        send_seq();
        expect_pulses(0, 1, "bad_addr");

        // Framing error while hunting is not a frame error.
        mark();
        send_byte(8'h55, 1'b0);
        expect_pulses(0, 0, "hunt_ferr");

        // Framing error in DATA aborts without writing.
        mark();
        seq = '{8'hA5, 8'h00, 8'h40, 8'h02, 8'h33};
        send_seq();
        apply_frame();
        send_byte(8'h77, 1'b0);
        expect_pulses(0, 1, "data_ferr");
        read_check(10'd64, 8'h33, "ferr_slot64");
        read_check(10'd65, 8'h00, "ferr_slot65");
        sweep();

        // Reset mid-DATA (count 256); stray bytes during the sweep are dropped.
        mark();
        seq = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h01, 8'h02, 8'h03};
        send_seq();
        read_check(10'd81, 8'h02, "pre_reset_slot81");
        @(negedge CLK12);
        reset = 1'b1;
        repeat (3) @(negedge CLK12);
        for (int i = 0; i < 512; i++) model_mem[i] = 8'h00;
        reset = 1'b0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_ready(512 - 2 * BYTE_CYC, "ready_after_stray");
        seq = '{8'h02, 8'h01, 8'h99};
        send_seq();
        expect_pulses(0, 0, "stray");
        read_check(10'd2, 8'h00, "stray_slot2");
        sweep();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
